// File: rtl/systolic_input_feeder.sv
// West-edge feeder for the systolic array: buffers activation vectors and skews them one row per cycle.
// Optional perf counters are enabled by defining SYSTOLIC_FEEDER_PERF_EN.
module systolic_input_feeder #(
   parameter int ROWS       = 4,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ROWS*DATA_WIDTH-1:0] in_data,
   input  logic                       in_switch,
   input  logic                       in_last,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       out_en,
   output logic [ROWS*DATA_WIDTH-1:0] row_input,
   output logic [ROWS-1:0]            row_valid,
   output logic [ROWS-1:0]            row_switch,
   output logic                       busy,
   output logic                       done
`ifdef SYSTOLIC_FEEDER_PERF_EN
   ,
   output logic [15:0]                perf_vec_count,
   output logic [15:0]                perf_bubble_count
`endif
);

   localparam int VW = ROWS * DATA_WIDTH;
   localparam int EW = VW + 2;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

   // Handshake: a vector transfers on any edge where in_valid && in_ready;
   // in_ready depends only on the registered fill level, never on this cycle's pop.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t         state;
   logic [CW-1:0]  drain_cnt;

   logic [EW-1:0]  mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   logic [EW-1:0]  head;
   logic           head_last;
   logic           head_switch;
   logic [VW-1:0]  head_data;

   assign full        = (count == (AW+1)'(DEPTH));
   assign empty       = (count == '0);
   assign in_ready    = !full;
   assign push        = in_valid && !full;
   // The final DRAIN cycle may already issue, so a queued batch follows done without a gap.
   assign pop         = !empty && out_en && ((state != DRAIN) || (drain_cnt == '0));
   assign head        = mem[rd_ptr];
   assign head_last   = head[EW-1];
   assign head_switch = head[EW-2];
   assign head_data   = head[VW-1:0];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_last, in_switch, in_data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         drain_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (push) begin
                  state <= STREAM;
                  busy  <= 1'b1;
               end
            end
            STREAM: begin
               if (pop && head_last) begin
                  state     <= DRAIN;
                  drain_cnt <= CW'(ROWS - 1);
                  done      <= (ROWS == 1);
               end
            end
            DRAIN: begin
               if (drain_cnt != '0) begin
                  drain_cnt <= drain_cnt - 1'b1;
                  done      <= (drain_cnt == CW'(1));
               end else if (pop && head_last) begin
                  drain_cnt <= CW'(ROWS - 1);
                  done      <= (ROWS == 1);
               end else if (!empty || push) begin
                  state <= STREAM;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Row r keeps r+1 slots of its own element; slot 0 is the issue stage.
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [DATA_WIDTH-1:0] d_q [r+1];
      logic [r:0]            v_q;
      logic [r:0]            s_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int k = 0; k <= r; k++) d_q[k] <= '0;
            v_q <= '0;
            s_q <= '0;
         end else begin
            d_q[0] <= pop ? head_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
            v_q[0] <= pop;
            s_q[0] <= pop && head_switch;
            for (int k = 1; k <= r; k++) begin
               d_q[k] <= d_q[k-1];
               v_q[k] <= v_q[k-1];
               s_q[k] <= s_q[k-1];
            end
         end
      end

      assign row_input[r*DATA_WIDTH +: DATA_WIDTH] = d_q[r];
      assign row_valid[r]                          = v_q[r];
      assign row_switch[r]                         = s_q[r];
   end

`ifdef SYSTOLIC_FEEDER_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_vec_count    <= '0;
         perf_bubble_count <= '0;
      end else begin
         if (pop && (perf_vec_count != 16'hFFFF))
            perf_vec_count <= perf_vec_count + 1'b1;
         if ((state == STREAM) && (empty || !out_en) && (perf_bubble_count != 16'hFFFF))
            perf_bubble_count <= perf_bubble_count + 1'b1;
      end
   end
`endif

endmodule
